// File: rtl/voxel_write_arbiter.sv
// ============================================================================
// Module      : voxel_write_arbiter
// Description : Shares the single write port of voxel_memory_64 among
//               NUM_REQ valid/ready requesters using round-robin arbitration
//               with bounded bursts and an exclusive lock for LOCK_OWNER.
//               The memory write strobe/address/data are registered.
//               Optional statistics counters: VOXEL_WRITE_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module voxel_write_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 64,
    parameter int BURST_MAX  = 16,
    parameter int LOCK_OWNER = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      lock,
    output logic                      write_en,
    output logic [ADDR_W-1:0]         write_addr,
    output logic [DATA_W-1:0]         write_data,
    output logic [2:0]                grant_id,
    output logic                      idle
`ifdef VOXEL_WRITE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*24-1:0]     grant_count,
    output logic [23:0]               lock_stall_count
`endif
);

    localparam logic [3:0] c_NREQ      = 4'(NUM_REQ);
    localparam logic [7:0] c_BURST_MAX = 8'(BURST_MAX);

    logic [NUM_REQ-1:0] w_eligible;
    logic [7:0]         w_elig8;
    logic               w_grant_vld;
    logic               w_hold;
    logic [2:0]         w_grant_idx;
    logic [3:0]         w_cand;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;

    logic [2:0]         r_owner;
    logic [7:0]         r_burst;

    // While lock is high only LOCK_OWNER may compete; ready is gated by rst.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign w_eligible[i] = req_valid[i] && (!lock || (i == LOCK_OWNER));
        assign w_grant_oh[i] = w_grant_vld && (w_grant_idx == 3'(i));
        assign req_ready[i]  = !rst && w_grant_oh[i];
    end

    // Zero-extend eligibility to 8 bits so it can be indexed by a 3-bit id.
    always_comb begin
        w_elig8 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig8[i] = w_eligible[i];
        end
    end

    // Grant selection: hold the owner while its burst allows, otherwise scan
    // owner+1 .. owner+NUM_REQ (the last step wraps back to the owner itself).
    // Scanning from the far end lets the nearest eligible index win.
    always_comb begin
        w_grant_vld = 1'b0;
        w_hold      = 1'b0;
        w_grant_idx = r_owner;
        w_cand      = '0;
        if (w_elig8[r_owner] && (r_burst < c_BURST_MAX)) begin
            w_grant_vld = 1'b1;
            w_hold      = 1'b1;
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                w_cand = {1'b0, r_owner} + 4'(k);
                if (w_cand >= c_NREQ) begin
                    w_cand = w_cand - c_NREQ;
                end
                if (w_elig8[w_cand[2:0]]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = w_cand[2:0];
                end
            end
        end
    end

    // One-hot mux of the granted requester's address and data.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Owner / burst bookkeeping; an idle cycle restarts the burst count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= 3'd0;
            r_burst <= 8'd0;
        end else if (!w_grant_vld) begin
            r_burst <= 8'd0;
        end else if (w_hold) begin
            r_burst <= r_burst + 8'd1;
        end else begin
            r_owner <= w_grant_idx;
            r_burst <= 8'd1;
        end
    end

    // Registered memory write port; address/data hold when no write occurs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            grant_id   <= 3'd0;
        end else begin
            write_en <= w_grant_vld;
            if (w_grant_vld) begin
                write_addr <= w_sel_addr;
                write_data <= w_sel_data;
                grant_id   <= w_grant_idx;
            end
        end
    end

    assign idle = !(|w_eligible) && !write_en;

`ifdef VOXEL_WRITE_ARB_STATS_EN
    localparam logic [NUM_REQ-1:0] c_OWNER_MASK = NUM_REQ'(1) << LOCK_OWNER;

    logic w_lock_stall;
    assign w_lock_stall = lock && (|(req_valid & ~c_OWNER_MASK));

    // Per-requester saturating count of writes presented to memory.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                grant_count[i*24 +: 24] <= 24'd0;
            end else if (write_en && (grant_id == 3'(i)) &&
                         (grant_count[i*24 +: 24] != 24'hFFFFFF)) begin
                grant_count[i*24 +: 24] <= grant_count[i*24 +: 24] + 24'd1;
            end
        end
    end

    // Saturating count of cycles in which the lock blocks a non-owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_stall_count <= 24'd0;
        end else if (w_lock_stall && (lock_stall_count != 24'hFFFFFF)) begin
            lock_stall_count <= lock_stall_count + 24'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_voxel_write_arbiter.sv
// ============================================================================
// Module      : tb_voxel_write_arbiter
// Description : Self-checking bench for voxel_write_arbiter. Two instances
//               (BURST_MAX=16 and BURST_MAX=1) share one stimulus stream and
//               are compared against a grant-rule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_voxel_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req_valid = 3'b000;
    logic        lock = 1'b0;
    logic [17:0] a_addr [3];
    logic [63:0] a_data [3];
    logic [53:0] req_addr;
    logic [191:0] req_data;

    logic [2:0]  rdy   [2];
    logic        we    [2];
    logic [17:0] waddr [2];
    logic [63:0] wdata [2];
    logic [2:0]  gid   [2];
    logic        idl   [2];

`ifdef VOXEL_WRITE_ARB_STATS_EN
    logic [71:0] gcnt [2];
    logic [23:0] lcnt [2];
`endif

    assign req_addr = {a_addr[2], a_addr[1], a_addr[0]};
    assign req_data = {a_data[2], a_data[1], a_data[0]};

    always #5 clk = ~clk;

    voxel_write_arbiter #(.NUM_REQ(3), .ADDR_W(18), .DATA_W(64), .BURST_MAX(16), .LOCK_OWNER(0)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_addr(req_addr), .req_data(req_data), .lock(lock),
        .write_en(we[0]), .write_addr(waddr[0]), .write_data(wdata[0]),
        .grant_id(gid[0]), .idle(idl[0])
`ifdef VOXEL_WRITE_ARB_STATS_EN
        , .grant_count(gcnt[0]), .lock_stall_count(lcnt[0])
`endif
    );

    voxel_write_arbiter #(.NUM_REQ(3), .ADDR_W(18), .DATA_W(64), .BURST_MAX(1), .LOCK_OWNER(0)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_addr(req_addr), .req_data(req_data), .lock(lock),
        .write_en(we[1]), .write_addr(waddr[1]), .write_data(wdata[1]),
        .grant_id(gid[1]), .idle(idl[1])
`ifdef VOXEL_WRITE_ARB_STATS_EN
        , .grant_count(gcnt[1]), .lock_stall_count(lcnt[1])
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: last granted index and length of its current run.
    int          bmax  [2] = '{16, 1};
    int          m_own [2];
    int          m_run [2];
    logic        exp_we   [2];
    logic [17:0] exp_addr [2];
    logic [63:0] exp_data [2];
    logic [2:0]  exp_gid  [2];
    int          g_a, g_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Keep the current owner while its run is short enough, else the next
    // eligible requester in circular order after it (possibly itself again).
    function automatic int ref_pick(input logic [2:0] el, input int last, input int run, input int bm);
        if (el[last[1:0]] && run < bm) return last;
        for (int k = 1; k <= 3; k++) begin
            int j;
            j = (last + k) % 3;
            if (el[j[1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_own[d] = 0; m_run[d] = 0;
            exp_we[d] = 1'b0; exp_addr[d] = '0; exp_data[d] = '0; exp_gid[d] = '0;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) chk("rst_async_we", 64'(we[d]), 64'(0));
        model_reset();
        repeat (n) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("rst_ready", 64'(rdy[d]), 64'(0));
                chk("rst_we", 64'(we[d]), 64'(0));
                chk("rst_addr", 64'(waddr[d]), 64'(0));
                chk("rst_gid", 64'(gid[d]), 64'(0));
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock: check ready/idle mid-cycle, advance the model, check writes.
    task automatic step();
        logic [2:0] el;
        logic [2:0] er;
        int p;
        @(negedge clk);
        el = req_valid & (lock ? 3'b001 : 3'b111);
        for (int d = 0; d < 2; d++) begin
            p  = ref_pick(el, m_own[d], m_run[d], bmax[d]);
            er = (p < 0) ? 3'b000 : (3'b001 << p);
            chk("ready", 64'(rdy[d]), 64'(er));
            chk("idle", 64'(idl[d]), 64'((el == 3'b000) && !exp_we[d]));
            if (p < 0) begin
                m_run[d]  = 0;
                exp_we[d] = 1'b0;
            end else begin
                if (p == m_own[d] && m_run[d] < bmax[d]) begin
                    m_run[d]++;
                end else begin
                    m_own[d] = p;
                    m_run[d] = 1;
                end
                exp_we[d]   = 1'b1;
                exp_addr[d] = a_addr[p];
                exp_data[d] = a_data[p];
                exp_gid[d]  = 3'(p);
            end
            if (d == 0) g_a = p; else g_b = p;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("write_en", 64'(we[d]), 64'(exp_we[d]));
            chk("write_addr", 64'(waddr[d]), 64'(exp_addr[d]));
            chk("write_data", wdata[d], exp_data[d]);
            chk("grant_id", 64'(gid[d]), 64'(exp_gid[d]));
        end
    endtask

    initial begin
        int prev, last, run, cnt, cyc;
        logic [17:0] held;
        for (int i = 0; i < 3; i++) begin
            a_addr[i] = 18'($urandom);
            a_data[i] = {$urandom, $urandom};
        end

        // Reset with every requester valid, then idle after release.
        req_valid = 3'b111;
        do_reset(3);
        req_valid = 3'b000;
        step();
        chk("idle_after_reset", 64'(idl[0]), 64'(1));

        // Single requester 1.
        req_valid = 3'b010; a_addr[1] = 18'h00ABC; a_data[1] = 64'h1234;
        step();
        chk("single_addr", 64'(waddr[0]), 64'h00ABC);
        chk("single_data", wdata[0], 64'h1234);
        chk("single_gid", 64'(gid[0]), 64'd1);
        req_valid = 3'b000;
        step();

        // Round-robin with BURST_MAX=1: strictly rotating, gap-free grants.
        req_valid = 3'b111;
        step();
        prev = g_b;
        for (int s = 0; s < 9; s++) begin
            step();
            chk("rr_order", 64'(g_b), 64'((prev + 1) % 3));
            chk("rr_no_gap", 64'(we[1]), 64'(1));
            prev = g_b;
        end

        // Bursts of 16 alternate between requesters 0 and 2.
        req_valid = 3'b101; last = -1; run = 0;
        for (int s = 0; s < 64; s++) begin
            step();
            if (g_a == last) run++;
            else begin
                if (last >= 0) chk("burst_len", 64'(run), 64'd16);
                last = g_a; run = 1;
            end
        end

        // Lone requester gets every cycle.
        req_valid = 3'b100;
        for (int s = 0; s < 20; s++) begin
            step();
            chk("lone_gid", 64'(gid[0]), 64'd2);
        end

        // Lock arrives while requester 1 is mid-burst.
        req_valid = 3'b010;
        repeat (3) step();
        held = 18'h2A5A5; a_addr[1] = held; a_data[1] = 64'hFEED;
        a_addr[0] = 18'd0; lock = 1'b1; req_valid = 3'b011;
        step();
        chk("lock_first_grant", 64'(g_a), 64'd0);
        cnt = 1; a_addr[0] = 18'd1; cyc = 0;
        while (cnt < 4096 && cyc < 5000) begin
            step();
            chk("lock_exclusive", 64'(g_a), 64'd0);
            if (g_a == 0) begin cnt++; a_addr[0] = 18'(cnt); end
            cyc++;
        end
        chk("gen_stream_done", 64'(cnt), 64'd4096);
        lock = 1'b0; req_valid = 3'b010; cnt = 0;
        for (int s = 0; s < 4; s++) begin
            step();
            if (g_a == 1) req_valid = 3'b000;
            if (we[0] && gid[0] == 3'd1 && waddr[0] == held) cnt++;
        end
        chk("resume_once", 64'(cnt), 64'd1);

        // Randomized traffic with lock toggling and a mid-run reset.
        for (int s = 0; s < 1500; s++) begin
            if (s == 750) begin
                do_reset(2);
            end
            step();
            for (int i = 0; i < 3; i++) begin
                if (req_valid[i] && g_a == i) req_valid[i] = 1'b0;
                else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    req_valid[i] = 1'b1;
                    a_addr[i] = 18'($urandom);
                    a_data[i] = {$urandom, $urandom};
                end
            end
            if ($urandom_range(0, 15) == 0) lock = ~lock;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
